// File: rtl/motor_move_sequencer.sv
// Motor move sequencer: accepts absolute/relative XY move commands, splits each move into
// segments that fit the stepper controller's signed pulse count, and tracks head position.
// Optional feature: define MOVE_SEQ_SOFT_LIMIT_EN to clamp resolved absolute targets to
// [0, X_MAX] x [0, Y_MAX].
module motor_move_sequencer #(
  parameter int unsigned POS_BITS         = 16,
  parameter int unsigned PULSE_NUM_BITS   = 12,
  parameter int unsigned PULSE_WIDTH_BITS = 16
`ifdef MOVE_SEQ_SOFT_LIMIT_EN
  ,
  parameter logic signed [POS_BITS-1:0] X_MAX = {1'b0, {(POS_BITS-1){1'b1}}},
  parameter logic signed [POS_BITS-1:0] Y_MAX = {1'b0, {(POS_BITS-1){1'b1}}}
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_rdy,
  input  logic signed [POS_BITS-1:0]         cmd_x,
  input  logic signed [POS_BITS-1:0]         cmd_y,
  input  logic                               cmd_rel,
  input  logic        [PULSE_WIDTH_BITS-1:0] cmd_pulse_width,
  input  logic                               set_zero,
  output logic signed [PULSE_NUM_BITS-1:0]   pulse_num_x,
  output logic signed [PULSE_NUM_BITS-1:0]   pulse_num_y,
  output logic        [PULSE_WIDTH_BITS-1:0] pulse_width,
  output logic                               trigger,
  input  logic                               xy_rdy,
  input  logic                               xy_done,
  output logic signed [POS_BITS-1:0]         pos_x,
  output logic signed [POS_BITS-1:0]         pos_y,
  output logic                               busy,
  output logic                               move_done
);

  // Remaining distance needs one extra bit: cmd - pos spans twice the position range.
  localparam int unsigned RW = POS_BITS + 1;

  typedef logic signed [RW-1:0]             rem_t;
  typedef logic signed [PULSE_NUM_BITS-1:0] seg_t;
  typedef logic signed [POS_BITS-1:0]       pos_t;

  localparam int   SegMaxInt = (1 << (PULSE_NUM_BITS - 1)) - 1;
  localparam rem_t SegMaxR   = rem_t'(SegMaxInt);
  localparam seg_t SegMax    = seg_t'(SegMaxInt);

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StIssue,
    StWaitDone,
    StUpdate,
    StFinish
  } state_e;

  state_e                      state_q, state_d;
  pos_t                        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  rem_t                        rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  seg_t                        seg_x_q, seg_x_d, seg_y_q, seg_y_d;
  logic [PULSE_WIDTH_BITS-1:0] pw_q, pw_d;

  // Symmetric clamp of a remaining distance to the largest per-segment pulse count.
  function automatic seg_t clamp_seg(input rem_t r);
    if (r > SegMaxR) begin
      return SegMax;
    end else if (r < -SegMaxR) begin
      return -SegMax;
    end else begin
      return seg_t'(r);
    end
  endfunction

`ifdef MOVE_SEQ_SOFT_LIMIT_EN
  function automatic pos_t clamp_target(input pos_t t, input pos_t lim);
    if (t < 0) begin
      return '0;
    end else if (t > lim) begin
      return lim;
    end else begin
      return t;
    end
  endfunction
`endif

  // Position seen by a newly accepted command; zeroing takes effect before acceptance.
  pos_t base_x, base_y;
  rem_t new_rem_x, new_rem_y;

  // Resolve the accepted command into the remaining distance per axis.
  always_comb begin
    base_x = pos_x_q;
    base_y = pos_y_q;
    if (set_zero) begin
      base_x = '0;
      base_y = '0;
    end
`ifdef MOVE_SEQ_SOFT_LIMIT_EN
    new_rem_x = rem_t'(clamp_target(cmd_rel ? pos_t'(base_x + cmd_x) : cmd_x, X_MAX))
                - rem_t'(base_x);
    new_rem_y = rem_t'(clamp_target(cmd_rel ? pos_t'(base_y + cmd_y) : cmd_y, Y_MAX))
                - rem_t'(base_y);
`else
    new_rem_x = cmd_rel ? rem_t'(cmd_x) : rem_t'(cmd_x) - rem_t'(base_x);
    new_rem_y = cmd_rel ? rem_t'(cmd_y) : rem_t'(cmd_y) - rem_t'(base_y);
`endif
  end

  // Next-state logic for the sequencer FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    rem_x_d = rem_x_q;
    rem_y_d = rem_y_q;
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    pw_d    = pw_q;
    unique case (state_q)
      StIdle: begin
        if (set_zero) begin
          pos_x_d = '0;
          pos_y_d = '0;
        end
        if (cmd_valid) begin
          rem_x_d = new_rem_x;
          rem_y_d = new_rem_y;
          pw_d    = cmd_pulse_width;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (rem_x_q == '0 && rem_y_q == '0) begin
          state_d = StFinish;
        end else begin
          seg_x_d = clamp_seg(rem_x_q);
          seg_y_d = clamp_seg(rem_y_q);
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (xy_rdy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (xy_done) state_d = StUpdate;
      end
      StUpdate: begin
        // Position wraps modulo 2^POS_BITS by truncation.
        pos_x_d = pos_x_q + POS_BITS'(seg_x_q);
        pos_y_d = pos_y_q + POS_BITS'(seg_y_q);
        rem_x_d = rem_x_q - RW'(seg_x_q);
        rem_y_d = rem_y_q - RW'(seg_y_q);
        state_d = StCalc;
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any move in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pos_x_q <= '0;
      pos_y_q <= '0;
      rem_x_q <= '0;
      rem_y_q <= '0;
      seg_x_q <= '0;
      seg_y_q <= '0;
      pw_q    <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      rem_x_q <= rem_x_d;
      rem_y_q <= rem_y_d;
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
      pw_q    <= pw_d;
    end
  end

  // Outputs decoded from state; trigger fires in the first ISSUE cycle the controller is ready.
  always_comb begin
    cmd_rdy     = (state_q == StIdle);
    busy        = (state_q != StIdle);
    trigger     = (state_q == StIssue) && xy_rdy;
    move_done   = (state_q == StFinish);
    pulse_num_x = seg_x_q;
    pulse_num_y = seg_y_q;
    pulse_width = pw_q;
    pos_x       = pos_x_q;
    pos_y       = pos_y_q;
  end

endmodule

// File: doc/motor_move_sequencer.md
MOTOR_MOVE_SEQUENCER -- requirements
Module: motor_move_sequencer

Interface
REQ-001 SHALL have parameter POS_BITS, default 16: signed width of absolute position and command coordinates.
REQ-002 SHALL have parameter PULSE_NUM_BITS, default 12: signed width of per-segment pulse counts sent to the XY stepper controller.
REQ-003 SHALL have parameter PULSE_WIDTH_BITS, default 16: unsigned width of base pulse width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid / cmd_rdy  in / out  1 / 1  command handshake; transfer when both are 1 on a clk edge.
REQ-007 cmd_x, cmd_y  in  POS_BITS  signed target, or signed offset when cmd_rel=1.
REQ-008 cmd_rel  in  1  1 = relative move, 0 = absolute move.
REQ-009 cmd_pulse_width  in  PULSE_WIDTH_BITS  base pulse width for the move.
REQ-010 set_zero  in  1  clears pos_x/pos_y; honoured only in IDLE.
REQ-011 pulse_num_x, pulse_num_y  out  PULSE_NUM_BITS  signed segment counts to the XY controller.
REQ-012 pulse_width  out  PULSE_WIDTH_BITS  registered copy of cmd_pulse_width.
REQ-013 trigger  out  1  one-cycle segment start strobe.
REQ-014 xy_rdy, xy_done  in  1 / 1  ready and done from the XY controller.
REQ-015 pos_x, pos_y  out  POS_BITS  signed tracked head position, registered.
REQ-016 busy / move_done  out  1 / 1  move in progress / one-cycle completion pulse.

Function
REQ-017 SHALL use states IDLE, CALC, ISSUE, WAIT_DONE, UPDATE, FINISH.
REQ-018 IDLE: cmd_rdy=1, busy=0; on transfer, latch rem_x/rem_y (POS_BITS+1 signed): cmd - pos for absolute, cmd for relative; latch pulse_width; go to CALC.
REQ-019 set_zero together with cmd_valid in IDLE: zeroing applies first, then the command is accepted against position 0.
REQ-020 CALC: if rem_x = rem_y = 0, go to FINISH with no trigger; otherwise register seg_x/seg_y = rem clamped to ±(2^(PULSE_NUM_BITS-1)-1) per axis, drive pulse_num_x/y, go to ISSUE.
REQ-021 ISSUE: assert trigger for exactly one cycle, in the first cycle with xy_rdy=1; then go to WAIT_DONE; trigger=0 in every other state.
REQ-022 WAIT_DONE: ignore xy_done in the trigger cycle; on the first xy_done=1 afterwards, go to UPDATE.
REQ-023 UPDATE: pos += seg, rem -= seg, same cycle; go to CALC.
REQ-024 FINISH: move_done=1 for one cycle; go to IDLE.
REQ-025 pulse_num_x/y and pulse_width SHALL stay stable from ISSUE until UPDATE.
REQ-026 Latency: cmd transfer to first trigger is 2 cycles when xy_rdy=1; final xy_done to move_done is 3 cycles.
REQ-027 Position arithmetic SHALL wrap modulo 2^POS_BITS; no saturation.
REQ-028 cmd_valid outside IDLE SHALL be ignored (cmd_rdy=0).

Reset
REQ-029 While reset=0: state=IDLE; pos_x, pos_y, pulse_num_x/y, pulse_width, trigger, move_done, busy = 0; cmd_rdy=1.
REQ-030 Reset mid-move SHALL abort immediately; the position of the partially executed segment is lost.

Configuration
REQ-031 With MOVE_SEQ_SOFT_LIMIT_EN defined: parameters X_MAX/Y_MAX (default 2^(POS_BITS-1)-1) SHALL be added; the resolved absolute target is clamped to [0, X_MAX] and [0, Y_MAX] before rem is computed.
REQ-032 Without MOVE_SEQ_SOFT_LIMIT_EN: no clamping; X_MAX/Y_MAX are absent.

Verification
REQ-033 pos=(0,0), absolute cmd (100,-50), xy_rdy=1, xy_done 5 cycles after trigger -> one trigger with pulse_num=(100,-50); pos=(100,-50); one move_done.
REQ-034 Defaults, absolute cmd (5000,10) from 0 -> segments (2047,10), (2047,0), (906,0); three triggers; final pos=(5000,10).
REQ-035 Relative cmd (0,0) -> no trigger; move_done 2 cycles after acceptance; pos unchanged.
REQ-036 xy_rdy held 0 for 10 cycles in ISSUE -> trigger withheld, then one 1-cycle trigger; xy_done=1 in trigger cycle ignored.
REQ-037 reset pulsed low during WAIT_DONE -> all outputs 0, cmd_rdy=1 next cycle; set_zero in IDLE -> pos=(0,0).
REQ-038 With MOVE_SEQ_SOFT_LIMIT_EN, X_MAX=1000: absolute cmd (1500,-20) -> pos ends (1000,0).
